// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full and
// almost-empty thresholds, optional first-word-fall-through read mode,
// same-cycle read+write while full, and registered overflow/underflow pulses.
//
// Parameters
//   DATA_WIDTH : word width in bits (>= 1)
//   DEPTH      : number of entries (power of two, >= 2)
//   FWFT       : 0 = registered read data, 1 = first-word-fall-through
//   AF_THRESH  : almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  : almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   CLK          : clock, rising edge
//   RST          : synchronous active-high reset
//   wr_en        : write request
//   data_in      : write data
//   rd_en        : read request (pop)
//   data_out     : read data
//   full, empty  : count == DEPTH / count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy 0..DEPTH
//   overflow     : one-cycle pulse, a write was rejected
//   underflow    : one-cycle pulse, a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_0   = CW'(0);
    localparam logic [CW-1:0] CNT_1   = CW'(1);
    localparam logic [AW-1:0] PTR_0   = AW'(0);
    localparam logic [AW-1:0] PTR_1   = AW'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_0 = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;

    // Flags are derived from the registered count at full count width.
    assign full_s   = (count_r == DEPTH_C);
    assign empty_s  = (count_r == CNT_0);
    // A read accepted while full frees the slot the concurrent write lands in.
    assign rd_acc_s = rd_en & ~empty_s;
    assign wr_acc_s = wr_en & (~full_s | rd_acc_s);

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AF_C);
    assign almost_empty = (count_r <= AE_C);
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_1;
            2'b01:   count_nxt_s = count_r - CNT_1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and error pulses; reset drops same-cycle requests.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r    <= PTR_0;
            rd_ptr_r    <= PTR_0;
            count_r     <= CNT_0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_1;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_1;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= wr_en & ~wr_acc_s;
            underflow_r <= rd_en & empty_s;
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while nothing is stored.
            always_comb begin
                data_out = DATA_0;
                if (empty_s) begin
                    data_out = DATA_0;
                end else begin
                    data_out = mem_r[rd_ptr_r];
                end
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_r;

            // Registered read; when full with a concurrent write the old word
            // is captured because the array update lands on the same edge.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    data_out_r <= DATA_0;
                end else if (rd_acc_s) begin
                    data_out_r <= mem_r[rd_ptr_r];
                end
            end

            assign data_out = data_out_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    logic       CLK;
    int         n_checks;
    int         n_fail;

    // Instance A: default parameters, standard read mode
    logic       a_rst, a_wr_en, a_rd_en;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    // Instance B: FWFT, DEPTH=4, AF=3, AE=0
    logic       b_rst, b_wr_en, b_rd_en;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    sync_fifo_flags u_dut_a (
        .CLK(CLK), .RST(a_rst), .wr_en(a_wr_en), .data_in(a_din), .rd_en(a_rd_en),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(0)) u_dut_b (
        .CLK(CLK), .RST(b_rst), .wr_en(b_wr_en), .data_in(b_din), .rd_en(b_rd_en),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", a_empty); end
        n_checks++; if (a_ae !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b exp 1", a_ae); end
        n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", a_full); end
        n_checks++; if (a_af !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", a_af); end
        n_checks++; if ({a_ovf, a_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {a_ovf, a_unf}); end
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", a_dout); end
        n_checks++; if (b_dout !== 8'h00 || b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b got dout=%h empty=%b exp 00/1", b_dout, b_empty); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1'b1; a_din = 8'(i);
            tick();
            n_checks++; if (a_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_count, i + 1); end
            n_checks++; if (a_af !== ((i + 1) >= 14)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, a_af, (i + 1) >= 14); end
            n_checks++; if (a_ae !== ((i + 1) <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b exp %b", i, a_ae, (i + 1) <= 2); end
            n_checks++; if (a_full !== ((i + 1) == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, a_full, (i + 1) == 16); end
        end
        a_din = 8'hAA;
        tick();
        a_wr_en = 1'b0;
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", a_ovf); end
        n_checks++; if (a_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", a_count); end
        tick();
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", a_ovf); end
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1;
            tick();
            n_checks++; if (a_dout !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, a_dout, 8'(i)); end
            n_checks++; if (a_count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, a_count, 15 - i); end
        end
        a_rd_en = 1'b0;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", a_empty); end
        n_checks++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL drain_unf got %b exp 0", a_unf); end
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1'b1; a_din = 8'(8'h80 + i);
            tick();
        end
        a_rd_en = 1'b1; a_din = 8'h55;
        tick();
        a_wr_en = 1'b0;
        n_checks++; if (a_dout !== 8'h80) begin n_fail++; $display("FAIL fullrw_data got %h exp 80", a_dout); end
        n_checks++; if (a_count !== 5'd16) begin n_fail++; $display("FAIL fullrw_count got %0d exp 16", a_count); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL fullrw_ovf got %b exp 0", a_ovf); end
        for (int i = 1; i < 17; i++) begin
            tick();
            n_checks++;
            if (a_dout !== ((i == 16) ? 8'h55 : 8'(8'h80 + i))) begin
                n_fail++; $display("FAIL fullrw_drain[%0d] got %h exp %h", i, a_dout, (i == 16) ? 8'h55 : 8'(8'h80 + i));
            end
        end
        a_rd_en = 1'b0;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL fullrw_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_empty_rw;
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_din = 8'h33;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL emptyrw_unf got %b exp 1", a_unf); end
        n_checks++; if (a_count !== 5'd1) begin n_fail++; $display("FAIL emptyrw_count got %0d exp 1", a_count); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL emptyrw_ovf got %b exp 0", a_ovf); end
        tick();
        n_checks++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL emptyrw_unf_clear got %b exp 0", a_unf); end
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        n_checks++; if (a_dout !== 8'h33) begin n_fail++; $display("FAIL emptyrw_data got %h exp 33", a_dout); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL emptyrw_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_wrap;
        // phases: prefill 3, up 12, both 5, down 12, up 12, both 8, down 15
        int         ph_n [7] = '{3, 12, 5, 12, 12, 8, 15};
        logic       ph_w [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       ph_r [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] q [$];
        logic [7:0] wval;
        logic [7:0] exp_d;
        wval = 8'h40;
        for (int p = 0; p < 7; p++) begin
            for (int k = 0; k < ph_n[p]; k++) begin
                exp_d = 8'h00;
                a_wr_en = ph_w[p]; a_rd_en = ph_r[p]; a_din = wval;
                if (ph_r[p]) exp_d = q.pop_front();
                if (ph_w[p]) begin q.push_back(wval); wval = wval + 8'd1; end
                tick();
                if (ph_r[p]) begin
                    n_checks++; if (a_dout !== exp_d) begin n_fail++; $display("FAIL wrap_data[%0d.%0d] got %h exp %h", p, k, a_dout, exp_d); end
                end
                n_checks++; if (a_count !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count[%0d.%0d] got %0d exp %0d", p, k, a_count, q.size()); end
                n_checks++; if (a_ae !== (q.size() <= 2)) begin n_fail++; $display("FAIL wrap_ae[%0d.%0d] got %b exp %b", p, k, a_ae, q.size() <= 2); end
                n_checks++; if (a_af !== (q.size() >= 14)) begin n_fail++; $display("FAIL wrap_af[%0d.%0d] got %b exp %b", p, k, a_af, q.size() >= 14); end
            end
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1'b1; a_din = 8'(8'hD0 + i);
            tick();
        end
        a_din = 8'hEE; a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_wr_en = 1'b0;
        n_checks++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b exp 1", a_empty); end
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b exp 0", a_ovf); end
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout got %h exp 00", a_dout); end
        a_wr_en = 1'b1; a_din = 8'h77;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        n_checks++; if (a_dout !== 8'h77) begin n_fail++; $display("FAIL rstmid_data got %h exp 77", a_dout); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_fwft;
        b_wr_en = 1'b1; b_din = 8'h11;
        tick();
        b_wr_en = 1'b0;
        n_checks++; if (b_dout !== 8'h11) begin n_fail++; $display("FAIL fwft_first got %h exp 11", b_dout); end
        n_checks++; if (b_ae !== 1'b0 || b_count !== 3'd1) begin n_fail++; $display("FAIL fwft_flags got ae=%b cnt=%0d exp 0/1", b_ae, b_count); end
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        n_checks++; if (b_dout !== 8'h00 || b_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop got dout=%h empty=%b exp 00/1", b_dout, b_empty); end
        for (int i = 0; i < 3; i++) begin
            b_wr_en = 1'b1; b_din = 8'(8'h21 + i);
            tick();
        end
        b_wr_en = 1'b0;
        n_checks++; if (b_af !== 1'b1 || b_full !== 1'b0) begin n_fail++; $display("FAIL fwft_af got af=%b full=%b exp 1/0", b_af, b_full); end
        n_checks++; if (b_dout !== 8'h21) begin n_fail++; $display("FAIL fwft_head got %h exp 21", b_dout); end
        b_rd_en = 1'b1;
        tick();
        n_checks++; if (b_dout !== 8'h22 || b_count !== 3'd2) begin n_fail++; $display("FAIL fwft_pop2 got dout=%h cnt=%0d exp 22/2", b_dout, b_count); end
        tick();
        n_checks++; if (b_dout !== 8'h23) begin n_fail++; $display("FAIL fwft_pop3 got %h exp 23", b_dout); end
        tick();
        n_checks++; if (b_dout !== 8'h00 || b_ae !== 1'b1) begin n_fail++; $display("FAIL fwft_drained got dout=%h ae=%b exp 00/1", b_dout, b_ae); end
        tick();
        b_rd_en = 1'b0;
        n_checks++; if (b_unf !== 1'b1) begin n_fail++; $display("FAIL fwft_unf got %b exp 1", b_unf); end
    endtask

    initial begin
        CLK = 1'b0;
        n_checks = 0; n_fail = 0;
        a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = 8'h00;
        b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = 8'h00;
        #2;
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_reset_mid();
        test_fwft();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
